// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle operation controller for the calculator's 8-bit ALU datapath.
// One request (opcode + two unsigned operands) is accepted at a time over a
// valid/ready handshake. Bitwise, add and subtract complete in one EXEC cycle.
// Multiply runs WIDTH shift-and-add steps. The registered result and its flags
// are returned over a second valid/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   request handshake (req_ready depends only on state and rst)
//   req_op            000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, others illegal
//   req_a, req_b      WIDTH-bit unsigned operands, sampled only at the accept edge
//   rsp_valid/ready   response handshake; rsp_* are held while rsp_ready is low
//   rsp_result        2*WIDTH-bit result
//   rsp_carry         ADD carry-out / SUB borrow
//   rsp_zero          rsp_result == 0
//   rsp_err           illegal opcode (or MUL when the multiplier is not built)
//   busy              controller is not idle
//
// Build option: define ALU_OP_SEQUENCER_MUL_EN to build the multiplier (MUL state,
// step counter, accumulator). Without it, opcode 101 is treated as illegal.
module alu_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
`endif

  localparam logic [2*WIDTH-1:0] RES_ZERO = {(2*WIDTH){1'b0}};

`ifdef ALU_OP_SEQUENCER_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  // Zero flag is always derived from the value actually loaded into rsp_result.
  function automatic logic is_zero(input logic [2*WIDTH-1:0] value);
    is_zero = (value == RES_ZERO);
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic                  accept_s;
  logic [2:0]            op_r;
  logic [WIDTH-1:0]      a_r;
  logic [WIDTH-1:0]      b_r;
  logic [WIDTH:0]        add_s;
  logic [WIDTH:0]        sub_s;
  logic [2*WIDTH-1:0]    exec_result_s;
  logic                  exec_carry_s;
  logic                  exec_err_s;

`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

  logic [STEP_W-1:0]     step_r;
  logic [2*WIDTH-1:0]    acc_r;
  logic [2*WIDTH-1:0]    mul_term_s;
  logic [2*WIDTH-1:0]    mul_sum_s;
`endif

  // Ready only in IDLE and never while reset is held; deliberately independent of req_valid.
  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef ALU_OP_SEQUENCER_MUL_EN
          if (req_op == OP_MUL) begin
            state_next_s = MUL;
          end else begin
            state_next_s = EXEC;
          end
`else
          state_next_s = EXEC;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = DONE;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      MUL: begin
        if (step_r == STEP_LAST) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MUL;
        end
      end
`endif
      DONE: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Single-cycle ALU result from the latched request; anything unrecognised is an error.
  always_comb begin
    add_s         = {1'b0, a_r} + {1'b0, b_r};
    sub_s         = {1'b0, a_r} - {1'b0, b_r};
    exec_result_s = RES_ZERO;
    exec_carry_s  = 1'b0;
    exec_err_s    = 1'b0;
    case (op_r)
      OP_AND: exec_result_s = {{WIDTH{1'b0}}, a_r & b_r};
      OP_OR:  exec_result_s = {{WIDTH{1'b0}}, a_r | b_r};
      OP_XOR: exec_result_s = {{WIDTH{1'b0}}, a_r ^ b_r};
      OP_ADD: begin
        exec_result_s = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
        exec_carry_s  = add_s[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is set exactly when a < b.
        exec_result_s = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};
        exec_carry_s  = sub_s[WIDTH];
      end
      default: exec_err_s = 1'b1;
    endcase
  end

`ifdef ALU_OP_SEQUENCER_MUL_EN
  // Shift-and-add partial product for the current multiplier bit.
  always_comb begin
    if (b_r[step_r]) begin
      mul_term_s = {{WIDTH{1'b0}}, a_r} << step_r;
    end else begin
      mul_term_s = RES_ZERO;
    end
    mul_sum_s = acc_r + mul_term_s;
  end
`endif

  // Request latch, multiply iteration and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 3'b000;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_result <= RES_ZERO;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      step_r     <= {STEP_W{1'b0}};
      acc_r      <= RES_ZERO;
`endif
    end else begin
      busy <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r <= req_op;
            a_r  <= req_a;
            b_r  <= req_b;
`ifdef ALU_OP_SEQUENCER_MUL_EN
            step_r <= {STEP_W{1'b0}};
            acc_r  <= RES_ZERO;
`endif
          end
        end
        EXEC: begin
          rsp_result <= exec_result_s;
          rsp_carry  <= exec_carry_s;
          rsp_zero   <= is_zero(exec_result_s);
          rsp_err    <= exec_err_s;
          rsp_valid  <= 1'b1;
        end
`ifdef ALU_OP_SEQUENCER_MUL_EN
        MUL: begin
          acc_r <= mul_sum_s;
          if (step_r == STEP_LAST) begin
            // Last step: the product goes straight to the response registers.
            step_r     <= {STEP_W{1'b0}};
            rsp_result <= mul_sum_s;
            rsp_carry  <= 1'b0;
            rsp_zero   <= is_zero(mul_sum_s);
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
          end else begin
            step_r <= step_r + STEP_W'(1);
          end
        end
`endif
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {err, carry, zero, result[15:0]} from plain arithmetic.
  function automatic logic [18:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned res;
    int diff;
    bit carry;
    bit err;
    res = 0; carry = 1'b0; err = 1'b0;
    case (op)
      3'd0: res = int'(a & b);
      3'd1: res = int'(a | b);
      3'd2: res = int'(a ^ b);
      3'd3: begin
        res   = (int'(a) + int'(b)) % 256;
        carry = (int'(a) + int'(b)) > 255;
      end
      3'd4: begin
        diff = int'(a) - int'(b);
        if (diff < 0) diff += 256;
        res   = diff;
        carry = (a < b);
      end
      3'd5: begin
        if (MUL_EN) res = int'(a) * int'(b);
        else err = 1'b1;
      end
      default: err = 1'b1;
    endcase
    model = {err, carry, (res == 0), 16'(res)};
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [18:0] exp;
    int lat;
    int exp_lat;
    exp = model(op, a, b);
    exp_lat = (op == 3'd5 && MUL_EN) ? 8 : 1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1 chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble request lines: they must be ignored after the accept edge.
    req_valid = 1'b0; req_op = 3'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", 32'(rsp_result), 32'(exp[15:0]));
    chk("zero", 32'(rsp_zero), 32'(exp[16]));
    chk("carry", 32'(rsp_carry), 32'(exp[17]));
    chk("err", 32'(rsp_err), 32'(exp[18]));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 3'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", 32'(rsp_result), 32'(exp[15:0]));
      chk("hold_flags", 32'({rsp_err, rsp_carry, rsp_zero}), 32'(exp[18:16]));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("taken_valid", 32'(rsp_valid), 32'd0);
    chk("taken_req_ready", 32'(req_ready), 32'd1);
    chk("taken_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'd0; req_b = 8'd0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_flags", 32'({rsp_err, rsp_carry, rsp_zero}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    do_op(3'b000, 8'hF0, 8'h3C, 0);
    do_op(3'b011, 8'hFF, 8'h01, 0);
    do_op(3'b100, 8'h05, 8'h07, 0);
    do_op(3'b101, 8'hFF, 8'hFF, 0);
    do_op(3'b101, 8'h12, 8'h34, 5);
    do_op(3'b111, 8'hAA, 8'h55, 0);

    // Reset in the middle of an operation: nothing must come out of it.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_a = 8'h0F; req_b = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_result", 32'(rsp_result), 32'd0);
    chk("midrst_flags", 32'({rsp_err, rsp_carry, rsp_zero}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_valid++;
    end
    chk("midrst_no_response", 32'(seen_valid), 32'd0);
    do_op(3'b011, 8'h01, 8'h02, 0);

    for (int n = 0; n < 24; n++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle operation controller for the calculator's 8-bit ALU datapath. Accepts one operation request at a time (opcode plus two operands) over a valid/ready handshake, runs single-cycle bitwise/add/subtract operations or an iterative shift-and-add multiply, and returns a registered result with status flags over a second valid/ready handshake. It sits between the keypad/command decoder and the display formatter.

## Interface
- WIDTH, 8, operand width in bits; result width is 2*WIDTH.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110/111 illegal
- req_a  in  WIDTH  operand A (unsigned)
- req_b  in  WIDTH  operand B (unsigned)
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_result  out  2*WIDTH  result
- rsp_carry  out  1  ADD carry-out / SUB borrow
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  illegal opcode, or MUL when multiply is compiled out
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: req_ready=1. On req_valid&req_ready at a rising edge: latch op, a, b. MUL goes to MUL; all other opcodes go to EXEC.
- EXEC: one cycle. Compute the result into the rsp registers, then go to DONE.
- MUL: WIDTH iterations, one per cycle, driven by a step counter. On each step, if multiplier bit i is 1, add (A << i) to the accumulator. When the counter reaches WIDTH-1, go to DONE.
- DONE: rsp_valid=1. Outputs are held stable until rsp_valid&rsp_ready, then go to IDLE.
- Result rules:
  - AND/OR/XOR: bitwise on WIDTH bits, zero-extended; carry=0.
  - ADD: low WIDTH bits = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum; upper bits 0.
  - SUB: low WIDTH bits = (a-b) mod 2^WIDTH; carry=1 iff a<b; upper bits 0.
  - MUL: full unsigned 2*WIDTH product; carry=0.
  - Illegal opcode: result=0, carry=0, zero=1, err=1.
  - zero is computed from the final result. err=0 for all legal operations.
- Request inputs are sampled only at the accept edge. Later changes are ignored.
- No overlap: a new request is accepted only in IDLE, so throughput is at most one op per latency+1 cycles.
- Reset, asserted at any time including mid-MUL or in DONE: state immediately becomes IDLE. The operation is discarded and no response is produced.

## Timing
- Reset values: rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0, busy=0, step counter=0.
- req_ready=0 while rst is high. It is 1 in the first cycle after deassertion.
- Accept at edge E:
  - Non-MUL ops: rsp_valid rises after edge E+1.
  - MUL: rsp_valid rises after edge E+WIDTH (8 cycles at default width).
- Response taken at edge R: rsp_valid=0 and req_ready=1 after R. The earliest next accept is edge R+1.
- rsp_ready held low: rsp_valid and all rsp_* outputs stay constant indefinitely.
- req_ready is a combinational function of state and rst only. It never depends on req_valid.

## Configuration
- ALU_OP_SEQUENCER_MUL_EN defined: the MUL state, step counter and accumulator are built. Opcode 101 multiplies as specified.
- Not defined: no MUL state or accumulator is built. Opcode 101 is handled exactly like an illegal opcode (one EXEC cycle, result=0, zero=1, err=1).

## Test plan
- AND a=0xF0, b=0x3C -> rsp_valid one cycle after accept; result=0x0030, carry=0, zero=0, err=0.
- ADD a=0xFF, b=0x01 -> result=0x0000, carry=1, zero=1. SUB a=0x05, b=0x07 -> result=0x00FE, carry=1.
- MUL a=0xFF, b=0xFF (macro defined) -> busy for 8 cycles; result=0xFE01, carry=0. Without the macro -> result=0, err=1 after 1 cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles after a MUL 0x12*0x34 completes -> result stays 0x03A8, req_ready stays 0 and req_valid is ignored; release rsp_ready -> req_ready=1 on the next cycle.
- Reset after step 3 of MUL 0x0F*0x0F -> rsp_valid never asserts; all outputs return to reset values; the next request ADD 0x01+0x02 -> 0x0003.
- Illegal opcode 111 with a=0xAA, b=0x55 -> result=0, zero=1, err=1, carry=0, one cycle after accept.
